// File: rtl/spi_flash_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_flash_reader                                                         |
// | Single-SPI READ (0x03) engine on quad flash pads with a streamed byte    |
// | output that honours consumer backpressure.                               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spi_flash_reader #(
  parameter int CLK_DIV        = 1,
  parameter int CS_HIGH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [23:0] i_req_addr,
  input  logic [15:0] i_req_len,
  output logic        o_rd_valid,
  input  logic        i_rd_ready,
  output logic [7:0]  o_rd_data,
  output logic        o_busy,
  output logic        o_flash_csb,
  output logic        o_flash_clk,
  output logic [3:0]  o_flash_io_do,
  output logic [3:0]  o_flash_io_oe,
  input  logic [3:0]  i_flash_io_di
);

  localparam int c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_cs_w  = $clog2(CS_HIGH_CYCLES + 1);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [c_cs_w-1:0]  c_cs_last  = c_cs_w'(CS_HIGH_CYCLES);
  localparam logic [7:0]         c_cmd_read = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHIFT_OUT = 2'd1,
    ST_SHIFT_IN  = 2'd2,
    ST_CS_HIGH   = 2'd3
  } state_t;

  state_t             r_state, w_state_next;
  logic [c_div_w-1:0] r_div;
  logic               r_sck, r_csb, r_mosi, r_rd_valid;
  logic [31:0]        r_sr_out;
  logic [5:0]         r_bit_cnt;
  logic [2:0]         r_bit_in_byte;
  logic [15:0]        r_bytes_left;
  logic [7:0]         r_sr_in, r_rd_data, w_sr_in_next;
  logic [c_cs_w-1:0]  r_cs_cnt;
  logic               w_start, w_stall, w_phase_end, w_fall, w_byte_done;
  logic               w_unused_di;

  assign o_req_ready  = (r_state == ST_IDLE) && !r_rd_valid;
  assign w_start      = i_req_valid && o_req_ready && (i_req_len != 16'd0);
  // Hold SCK low at a byte boundary while the previous byte is still unconsumed.
  assign w_stall      = (r_state == ST_SHIFT_IN) && (r_bit_in_byte == 3'd0) && !r_sck
                        && r_rd_valid && !i_rd_ready;
  assign w_phase_end  = ((r_state == ST_SHIFT_OUT) || (r_state == ST_SHIFT_IN))
                        && !w_stall && (r_div == c_div_last);
  assign w_fall       = w_phase_end && r_sck;
  assign w_byte_done  = w_fall && (r_state == ST_SHIFT_IN) && (r_bit_in_byte == 3'd7);
  assign w_sr_in_next = {r_sr_in[6:0], i_flash_io_di[1]};
  assign w_unused_di  = ^{i_flash_io_di[3:2], i_flash_io_di[0]};

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:      if (w_start) w_state_next = ST_SHIFT_OUT;
      ST_SHIFT_OUT: if (w_fall && (r_bit_cnt == 6'd31)) w_state_next = ST_SHIFT_IN;
      ST_SHIFT_IN:  if (w_byte_done && (r_bytes_left == 16'd1)) w_state_next = ST_CS_HIGH;
      ST_CS_HIGH:   if (r_cs_cnt == c_cs_last) w_state_next = ST_IDLE;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_csb         <= 1'b1;
      r_sck         <= 1'b0;
      r_mosi        <= 1'b0;
      r_div         <= '0;
      r_sr_out      <= '0;
      r_bit_cnt     <= '0;
      r_bit_in_byte <= '0;
      r_bytes_left  <= '0;
      r_sr_in       <= '0;
      r_rd_data     <= '0;
      r_rd_valid    <= 1'b0;
      r_cs_cnt      <= '0;
    end else begin
      if (w_byte_done)                    r_rd_valid <= 1'b1;
      else if (r_rd_valid && i_rd_ready)  r_rd_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_csb         <= 1'b0;
            r_sck         <= 1'b0;
            r_div         <= '0;
            r_mosi        <= c_cmd_read[7];
            r_sr_out      <= {c_cmd_read[6:0], i_req_addr, 1'b0};
            r_bit_cnt     <= '0;
            r_bit_in_byte <= '0;
            r_bytes_left  <= i_req_len;
          end
        end
        ST_SHIFT_OUT, ST_SHIFT_IN: begin
          r_cs_cnt <= '0;
          if (!w_stall) begin
            if (w_phase_end) begin
              r_div <= '0;
              r_sck <= ~r_sck;
            end else begin
              r_div <= r_div + 1'b1;
            end
          end
          // The shifter empties to zero, so MOSI idles low once data starts.
          if (w_fall && (r_state == ST_SHIFT_OUT)) begin
            r_bit_cnt <= r_bit_cnt + 6'd1;
            r_sr_out  <= {r_sr_out[30:0], 1'b0};
            r_mosi    <= r_sr_out[31];
          end
          if (w_fall && (r_state == ST_SHIFT_IN)) begin
            r_sr_in       <= w_sr_in_next;
            r_bit_in_byte <= r_bit_in_byte + 3'd1;
            if (r_bit_in_byte == 3'd7) begin
              r_rd_data    <= w_sr_in_next;
              r_bytes_left <= r_bytes_left - 16'd1;
            end
          end
        end
        ST_CS_HIGH: begin
          r_csb <= 1'b1;
          if (r_cs_cnt != c_cs_last) r_cs_cnt <= r_cs_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_rd_valid    = r_rd_valid;
  assign o_rd_data     = r_rd_data;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_flash_csb   = r_csb;
  assign o_flash_clk   = r_sck;
  assign o_flash_io_do = {2'b11, 1'b0, r_mosi};
  assign o_flash_io_oe = 4'b1101;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_flash_reader                                                      |
// | Directed bench: two readers (SCK divider 1 and 3) against a flash model. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, rd_ready;
  logic [23:0] req_addr;
  logic [15:0] req_len;
  logic [1:0]  req_ready, rd_valid, busy, csb, sck;
  logic [7:0]  rd_data [2];
  logic [3:0]  io_do [2];
  logic [3:0]  io_oe [2];
  logic [3:0]  io_di [2];

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem [2][16];
  int          fall_cnt [2];
  int          data_rises [2];
  int          sck_rises [2];
  int          csb_falls [2];
  int          sck_viol [2];
  logic [31:0] mosi_sr [2];
  logic        prev_sck [2];
  logic        prev_csb [2];
  int          m_idx;

  always #5 clk = ~clk;

  spi_flash_reader #(.CLK_DIV(1), .CS_HIGH_CYCLES(4)) u_dut1 (
    .clk(clk), .reset(reset),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_addr(req_addr), .i_req_len(req_len),
    .o_rd_valid(rd_valid[0]), .i_rd_ready(rd_ready[0]), .o_rd_data(rd_data[0]),
    .o_busy(busy[0]), .o_flash_csb(csb[0]), .o_flash_clk(sck[0]),
    .o_flash_io_do(io_do[0]), .o_flash_io_oe(io_oe[0]), .i_flash_io_di(io_di[0])
  );

  spi_flash_reader #(.CLK_DIV(3), .CS_HIGH_CYCLES(4)) u_dut3 (
    .clk(clk), .reset(reset),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_addr(req_addr), .i_req_len(req_len),
    .o_rd_valid(rd_valid[1]), .i_rd_ready(rd_ready[1]), .o_rd_data(rd_data[1]),
    .o_busy(busy[1]), .o_flash_csb(csb[1]), .o_flash_clk(sck[1]),
    .o_flash_io_do(io_do[1]), .o_flash_io_oe(io_oe[1]), .i_flash_io_di(io_di[1])
  );

  // Flash model: captures MOSI on SCK rise, presents the next data bit after SCK falls.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        io_di[i]    = 4'b0000;
        fall_cnt[i] = 0;
      end else begin
        if (prev_csb[i] && !csb[i]) begin
          fall_cnt[i] = 0;
          mosi_sr[i]  = '0;
          csb_falls[i]++;
        end
        if (csb[i] && sck[i]) sck_viol[i]++;
        if (!csb[i] && sck[i] && !prev_sck[i]) begin
          sck_rises[i]++;
          if (fall_cnt[i] < 32) mosi_sr[i] = {mosi_sr[i][30:0], io_do[i][0]};
          else                  data_rises[i]++;
        end
        if (!csb[i] && !sck[i] && prev_sck[i]) begin
          fall_cnt[i]++;
          if (fall_cnt[i] >= 32) begin
            m_idx = fall_cnt[i] - 32;
            io_di[i][1] = mem[i][(m_idx / 8) % 16][7 - (m_idx % 8)];
          end
        end
      end
      prev_csb[i] = csb[i];
      prev_sck[i] = sck[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input int i, input logic [23:0] a, input logic [15:0] n);
    req_addr     = a;
    req_len      = n;
    req_valid[i] = 1'b1;
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; rd_ready = 2'b11; req_addr = '0; req_len = '0;
    repeat (3) tick();
    checks++;
    if (io_oe[0] !== 4'b1101) begin errors++; $display("FAIL reset_oe_during: got %b want 1101", io_oe[0]); end
    reset = 1'b0;
    repeat (20) tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({csb[i], sck[i]} !== 2'b10) begin errors++; $display("FAIL reset_csb_sck dut%0d: got %b want 10", i, {csb[i], sck[i]}); end
      checks++;
      if (io_oe[i] !== 4'b1101) begin errors++; $display("FAIL reset_oe dut%0d: got %b want 1101", i, io_oe[i]); end
      checks++;
      if (io_do[i] !== 4'b1100) begin errors++; $display("FAIL reset_do dut%0d: got %b want 1100", i, io_do[i]); end
      checks++;
      if ({req_ready[i], rd_valid[i], busy[i]} !== 3'b100) begin
        errors++; $display("FAIL reset_handshake dut%0d: got %b want 100", i, {req_ready[i], rd_valid[i], busy[i]});
      end
      checks++;
      if (rd_data[i] !== 8'h00) begin errors++; $display("FAIL reset_rd_data dut%0d: got %h want 00", i, rd_data[i]); end
    end
  endtask

  task automatic test_single();
    int c;
    int r0;
    mem[0][0] = 8'hA5; rd_ready[0] = 1'b1;
    r0 = data_rises[0];
    start_req(0, 24'h123456, 16'd1);
    checks++;
    if ({csb[0], busy[0]} !== 2'b01) begin errors++; $display("FAIL single_csb_fall: got csb,busy=%b want 01", {csb[0], busy[0]}); end
    c = 0;
    while (rd_valid[0] !== 1'b1 && c < 200) begin tick(); c++; end
    checks++;
    if (c != 80) begin errors++; $display("FAIL single_latency: got %0d want 80", c); end
    checks++;
    if (rd_data[0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", rd_data[0]); end
    checks++;
    if (csb[0] !== 1'b0) begin errors++; $display("FAIL single_csb_at_byte: got %b want 0", csb[0]); end
    tick(); c++;
    checks++;
    if ({csb[0], rd_valid[0]} !== 2'b10) begin errors++; $display("FAIL single_csb_rise: got csb,valid=%b want 10", {csb[0], rd_valid[0]}); end
    while (req_ready[0] !== 1'b1 && c < 300) begin tick(); c++; end
    checks++;
    if (c != 85) begin errors++; $display("FAIL single_req_ready: got %0d want 85", c); end
    checks++;
    if (mosi_sr[0] !== 32'h03123456) begin errors++; $display("FAIL single_mosi: got %h want 03123456", mosi_sr[0]); end
    checks++;
    if (data_rises[0] - r0 != 8) begin errors++; $display("FAIL single_data_sck: got %0d want 8", data_rises[0] - r0); end
  endtask

  task automatic test_multi();
    int c, n, r0;
    int t [4];
    logic [7:0] d [4];
    logic [7:0] exp_b [4];
    exp_b = '{8'h00, 8'hFF, 8'h5A, 8'hC3};
    for (int k = 0; k < 4; k++) mem[0][k] = exp_b[k];
    rd_ready[0] = 1'b1;
    r0 = data_rises[0];
    start_req(0, 24'h000100, 16'd4);
    c = 0; n = 0;
    while (req_ready[0] !== 1'b1 && c < 400) begin
      tick(); c++;
      if (rd_valid[0] === 1'b1) begin
        if (n < 4) begin t[n] = c; d[n] = rd_data[0]; end
        n++;
      end
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL multi_count: got %0d want 4", n); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (t[k] != 80 + 16 * k || d[k] !== exp_b[k]) begin
        errors++; $display("FAIL multi_byte%0d: got t=%0d d=%h want t=%0d d=%h", k, t[k], d[k], 80 + 16 * k, exp_b[k]);
      end
    end
    checks++;
    if (data_rises[0] - r0 != 32) begin errors++; $display("FAIL multi_data_sck: got %0d want 32", data_rises[0] - r0); end
  endtask

  task automatic test_backpressure();
    int c, n, bad, r0, rs;
    logic [7:0] d [2];
    mem[0][0] = 8'h81; mem[0][1] = 8'h7E; mem[0][2] = 8'h3C;
    rd_ready[0] = 1'b0;
    rs = sck_rises[0];
    start_req(0, 24'hFEDCBA, 16'd3);
    c = 0;
    while (rd_valid[0] !== 1'b1 && c < 200) begin tick(); c++; end
    checks++;
    if (c != 80 || rd_data[0] !== 8'h81) begin errors++; $display("FAIL bp_first: got t=%0d d=%h want t=80 d=81", c, rd_data[0]); end
    r0 = sck_rises[0]; bad = 0;
    repeat (50) begin
      tick();
      if (sck[0] !== 1'b0 || csb[0] !== 1'b0 || rd_valid[0] !== 1'b1 || rd_data[0] !== 8'h81) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_stall_hold: got %0d bad cycles want 0", bad); end
    checks++;
    if (sck_rises[0] != r0) begin errors++; $display("FAIL bp_no_edges: got %0d rises want 0", sck_rises[0] - r0); end
    rd_ready[0] = 1'b1;
    c = 0; n = 0;
    while (req_ready[0] !== 1'b1 && c < 400) begin
      tick(); c++;
      if (rd_valid[0] === 1'b1) begin
        if (n < 2) d[n] = rd_data[0];
        n++;
      end
    end
    checks++;
    if (n != 2 || d[0] !== 8'h7E || d[1] !== 8'h3C) begin
      errors++; $display("FAIL bp_rest: got n=%0d %h %h want n=2 7e 3c", n, d[0], d[1]);
    end
    checks++;
    if (sck_rises[0] - rs != 56) begin errors++; $display("FAIL bp_total_sck: got %0d want 56", sck_rises[0] - rs); end
  endtask

  task automatic test_len0();
    int f0;
    f0 = csb_falls[0];
    checks++;
    if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL len0_ready_before: got %b want 1", req_ready[0]); end
    start_req(0, 24'h555555, 16'd0);
    checks++;
    if ({req_ready[0], busy[0], csb[0]} !== 3'b101) begin
      errors++; $display("FAIL len0_idle: got ready,busy,csb=%b want 101", {req_ready[0], busy[0], csb[0]});
    end
    repeat (10) tick();
    checks++;
    if (csb_falls[0] != f0 || csb[0] !== 1'b1) begin errors++; $display("FAIL len0_no_bus: got %0d csb falls want 0", csb_falls[0] - f0); end
  endtask

  task automatic test_reset_mid();
    int c;
    rd_ready[0] = 1'b1;
    for (int k = 0; k < 8; k++) mem[0][k] = 8'(k * 17);
    start_req(0, 24'h000000, 16'd8);
    repeat (39) tick();
    checks++;
    if (sck[0] !== 1'b1) begin errors++; $display("FAIL rm_sck_before: got %b want 1", sck[0]); end
    reset = 1'b1;
    tick();
    checks++;
    if ({csb[0], sck[0], rd_valid[0], busy[0]} !== 4'b1000) begin
      errors++; $display("FAIL rm_applied: got csb,sck,valid,busy=%b want 1000", {csb[0], sck[0], rd_valid[0], busy[0]});
    end
    reset = 1'b0;
    tick();
    mem[0][0] = 8'h3C;
    start_req(0, 24'hABCDEF, 16'd1);
    c = 0;
    while (rd_valid[0] !== 1'b1 && c < 200) begin tick(); c++; end
    checks++;
    if (c != 80 || rd_data[0] !== 8'h3C) begin errors++; $display("FAIL rm_after: got t=%0d d=%h want t=80 d=3c", c, rd_data[0]); end
    while (req_ready[0] !== 1'b1 && c < 300) begin tick(); c++; end
    checks++;
    if (mosi_sr[0] !== 32'h03ABCDEF || c != 85) begin
      errors++; $display("FAIL rm_after_mosi: got %h t=%0d want 03abcdef t=85", mosi_sr[0], c);
    end
  endtask

  task automatic test_div3();
    int c, n, run, bad, first_rise;
    logic last;
    int t [2];
    logic [7:0] d [2];
    mem[1][0] = 8'h96; mem[1][1] = 8'h69; rd_ready[1] = 1'b1;
    start_req(1, 24'h0F1E2D, 16'd2);
    c = 0; n = 0; run = 1; bad = 0; first_rise = -1; last = sck[1];
    while (req_ready[1] !== 1'b1 && c < 1000) begin
      tick(); c++;
      if (sck[1] === last) run++;
      else begin
        if (run != 3) bad++;
        if (first_rise < 0) first_rise = c;
        run = 1; last = sck[1];
      end
      if (rd_valid[1] === 1'b1) begin
        if (n < 2) begin t[n] = c; d[n] = rd_data[1]; end
        n++;
      end
    end
    checks++;
    if (first_rise != 3) begin errors++; $display("FAIL div3_first_rise: got %0d want 3", first_rise); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL div3_phase_len: got %0d bad phases want 0", bad); end
    checks++;
    if (n != 2 || t[0] != 240 || d[0] !== 8'h96) begin
      errors++; $display("FAIL div3_byte0: got n=%0d t=%0d d=%h want n=2 t=240 d=96", n, t[0], d[0]);
    end
    checks++;
    if (t[1] != 288 || d[1] !== 8'h69) begin errors++; $display("FAIL div3_byte1: got t=%0d d=%h want t=288 d=69", t[1], d[1]); end
    checks++;
    if (c != 293) begin errors++; $display("FAIL div3_req_ready: got %0d want 293", c); end
    checks++;
    if (mosi_sr[1] !== 32'h030F1E2D) begin errors++; $display("FAIL div3_mosi: got %h want 030f1e2d", mosi_sr[1]); end
  endtask

  task automatic test_invariants();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (sck_viol[i] != 0) begin errors++; $display("FAIL sck_high_csb_high dut%0d: got %0d cycles want 0", i, sck_viol[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_len0();
    test_reset_mid();
    test_div3();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
